neuron_accumulator: RTL and testbench

Downstream stage of the accelerator FSM. It takes the 16 parallel PE products of each MAC group and reduces them in a pipelined adder tree. Group sums are accumulated across all MAC groups of one output neuron. When the FSM signals the neuron complete, the block writes the saturated (optionally ReLU'd) result to the output BRAM at the FSM-supplied output address.

---
 rtl/accel_pkg.sv | 34 +++
 rtl/pe_adder_tree.sv | 86 ++++++++
 rtl/neuron_accumulator.sv | 125 ++++++++++++
 tb/tb_neuron_accumulator.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared defaults and helpers for the accelerator datapath.
// Holds the PE/accumulator width defaults, the derived adder-tree depth
// and a generic signed saturation helper.
package accel_pkg;

  localparam int DEF_LANES = 16;
  localparam int DEF_DW    = 16;
  localparam int DEF_AW    = 16;
  localparam int DEF_ACC_W = 24;
  localparam int TREE_LVLS = $clog2(DEF_LANES);

  // Clamp a signed value to the range of an ow-bit signed number.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      sat_clamp = hi;
    else if (v < lo) sat_clamp = lo;
    else             sat_clamp = v;
  endfunction

  // True when v does not fit in an ow-bit signed number.
  function automatic logic sat_hit(input logic signed [63:0] v,
                                   input int unsigned ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    sat_hit = (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Pipelined LANES-input signed reduction tree with valid/last sideband.
// Stage 0 captures the products; stages 1..LVLS each add adjacent pairs.
// All stages are held at the final sum width; a level-l value only ever
// needs DW+l bits, so the unused upper/extra entries are constant zero.
// tag marks the youngest valid item as the last group of its neuron; a tag
// that hits the output stage is reflected combinationally on out_last.
module pe_adder_tree
  import accel_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  parameter  int DW    = DEF_DW,
  localparam int LVLS  = $clog2(LANES),
  localparam int SUM_W = DW + LVLS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [LANES*DW-1:0]     in_data,
  input  logic                    tag,
  output logic                    out_valid,
  output logic                    out_last,
  output logic signed [SUM_W-1:0] out_sum,
  output logic                    any_valid
);

  logic signed [SUM_W-1:0] data_d [LVLS+1][LANES];
  logic signed [SUM_W-1:0] data_q [LVLS+1][LANES];
  logic [LVLS:0] valid_d, valid_q;
  logic [LVLS:0] last_d, last_q;
  logic [LVLS:0] tag_hit;

  // Datapath: capture products in stage 0, pairwise sums in later stages.
  always_comb begin
    for (int l = 0; l <= LVLS; l++) begin
      for (int i = 0; i < LANES; i++) data_d[l][i] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      data_d[0][i] = in_valid ? SUM_W'($signed(in_data[i*DW +: DW])) : data_q[0][i];
    end
    for (int l = 1; l <= LVLS; l++) begin
      for (int i = 0; i < (LANES >> l); i++) begin
        data_d[l][i] = data_q[l-1][2*i] + data_q[l-1][2*i+1];
      end
    end
  end

  // Data stages carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  // Sideband: shift valid/last, applying a tag to the youngest valid item.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    tag_hit = '0;
    for (int k = 0; k <= LVLS; k++) begin
      tag_hit[k] = tag & valid_q[k] & ~seen;
      seen       = seen | valid_q[k];
    end
    valid_d    = '0;
    last_d     = '0;
    valid_d[0] = in_valid;
    for (int k = 1; k <= LVLS; k++) begin
      valid_d[k] = valid_q[k-1];
      last_d[k]  = valid_q[k-1] & (last_q[k-1] | tag_hit[k-1]);
    end
  end

  // Sideband registers, cleared by reset so in-flight groups are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q[LVLS];
  assign out_last  = last_q[LVLS] | tag_hit[LVLS];
  assign out_sum   = data_q[LVLS][0];
  assign any_valid = |valid_q;

endmodule

// File: rtl/neuron_accumulator.sv
// Neuron accumulator: reduces each MAC group's PE products, accumulates
// group sums per neuron and writes the saturated result to output BRAM.
// Optional feature macro ACC_RELU_EN: clamp negative results to zero.
//
// Handshakes: add_done/prod_data and neuron_done/out_addr are single-cycle
// valid pulses with no ready (the upstream FSM guarantees spacing);
// wr_en is a one-cycle valid strobe qualifying wr_addr/wr_data, no ready.
module neuron_accumulator
  import accel_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*DW-1:0] prod_data,
  input  logic                add_done,
  input  logic                neuron_done,
  input  logic [AW-1:0]       out_addr,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [DW-1:0]       wr_data,
  output logic                busy,
  output logic                ovf,
  output logic                err
);

  localparam int SUM_W = DW + $clog2(LANES);

  logic                    tree_valid, tree_last, tree_any;
  logic signed [SUM_W-1:0] tree_sum;

  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic [AW-1:0]           addr_d, addr_q;
  logic                    wr_en_d, wr_en_q;
  logic [AW-1:0]           wr_addr_d, wr_addr_q;
  logic [DW-1:0]           wr_data_d, wr_data_q;
  logic                    ovf_d, ovf_q;
  logic                    err_d, err_q;

  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [DW-1:0]    out_sat;

  pe_adder_tree #(.LANES(LANES), .DW(DW)) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (add_done),
    .in_data   (prod_data),
    .tag       (neuron_done),
    .out_valid (tree_valid),
    .out_last  (tree_last),
    .out_sum   (tree_sum),
    .any_valid (tree_any)
  );

  // Tagging, accumulation with saturation, and write generation.
  always_comb begin
    acc_d     = acc_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q;
    err_d     = err_q;

    acc_sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(ACC_W'(tree_sum));
    acc_sat = ACC_W'(sat_clamp(64'(acc_sum), ACC_W));
    out_sat = DW'(sat_clamp(64'(acc_sat), DW));

    // A completion pulse with nothing in flight cannot be attributed.
    if (neuron_done) begin
      if (tree_any) addr_d = out_addr;
      else          err_d  = 1'b1;
    end

    if (tree_valid) begin
      if (sat_hit(64'(acc_sum), ACC_W)) ovf_d = 1'b1;
      if (tree_last) begin
        acc_d     = '0;
        wr_en_d   = 1'b1;
        wr_addr_d = addr_d;
        if (sat_hit(64'(acc_sat), DW)) ovf_d = 1'b1;
`ifdef ACC_RELU_EN
        wr_data_d = out_sat[DW-1] ? '0 : out_sat;
`else
        wr_data_d = out_sat;
`endif
      end else begin
        acc_d = acc_sat;
      end
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign ovf     = ovf_q;
  assign err     = err_q;
  assign busy    = tree_any | wr_en_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Testbench for neuron_accumulator: directed and random MAC groups checked
// against an arithmetic neuron model through an expected-write queue.
module tb_neuron_accumulator;

  localparam int LANES = 16;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int ACC_W = 24;
  localparam int EW    = AW + DW + 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [LANES*DW-1:0] prod_data;
  logic                add_done;
  logic                neuron_done;
  logic [AW-1:0]       out_addr;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic                busy;
  logic                ovf;
  logic                err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // expected write: {addr, data, cycle in which wr_en must be seen}
  logic [EW-1:0] exp_q[$];

  // neuron model state
  longint m_acc = 0;
  bit     m_ovf = 1'b0;
  bit     m_err = 1'b0;

  neuron_accumulator #(.LANES(LANES), .DW(DW), .AW(AW), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .prod_data   (prod_data),
    .add_done    (add_done),
    .neuron_done (neuron_done),
    .out_addr    (out_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .ovf         (ovf),
    .err         (err)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint lo_of(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
  function automatic longint hi_of(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic longint clamp(input longint v, input int w);
    if (v > hi_of(w)) return hi_of(w);
    if (v < lo_of(w)) return lo_of(w);
    return v;
  endfunction
  function automatic bit over(input longint v, input int w);
    return (v > hi_of(w)) || (v < lo_of(w));
  endfunction
  function automatic longint group_sum(input logic [LANES*DW-1:0] pd);
    longint s = 0;
    for (int i = 0; i < LANES; i++) begin
      logic signed [DW-1:0] lane;
      lane = pd[i*DW +: DW];
      s += longint'(lane);
    end
    return s;
  endfunction

  // Apply one group to the model; a tagged group produces an expected write.
  task automatic issue_model(input logic [LANES*DW-1:0] pd, input bit tag,
                             input logic [AW-1:0] addr, input int t);
    longint s;
    longint o;
    s = m_acc + group_sum(pd);
    if (over(s, ACC_W)) m_ovf = 1'b1;
    m_acc = clamp(s, ACC_W);
    if (tag) begin
      if (over(m_acc, DW)) m_ovf = 1'b1;
      o = clamp(m_acc, DW);
`ifdef ACC_RELU_EN
      if (o < 0) o = 0;
`endif
      exp_q.push_back({addr, DW'(o), 32'(t + 6)});
      m_acc = 0;
    end
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] v);
    logic [LANES*DW-1:0] pd;
    for (int i = 0; i < LANES; i++) pd[i*DW +: DW] = v;
    return pd;
  endfunction

  function automatic logic [LANES*DW-1:0] rand_group();
    logic [LANES*DW-1:0] pd;
    int mode;
    mode = int'($urandom_range(0, 3));
    for (int i = 0; i < LANES; i++) begin
      if (mode == 0) pd[i*DW +: DW] = DW'($urandom);
      else           pd[i*DW +: DW] = DW'(int'($urandom_range(0, 600)) - 300);
    end
    return pd;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // add_done in cycle T, neuron_done (if tagged) in cycle T+dly, dly in 1..5.
  task automatic drive_group(input logic [LANES*DW-1:0] pd, input bit tag,
                             input int dly, input logic [AW-1:0] addr);
    issue_model(pd, tag, addr, cyc);
    prod_data = pd;
    add_done  = 1'b1;
    @(negedge clk);
    add_done  = 1'b0;
    prod_data = {LANES{DW'($urandom)}};
    for (int d = 1; d <= 5; d++) begin
      if (tag && d == dly) begin
        neuron_done = 1'b1;
        out_addr    = addr;
      end
      @(negedge clk);
      neuron_done = 1'b0;
      out_addr    = AW'($urandom);
    end
  endtask

  task automatic check_flags(input string tagname);
    check({tagname, "_ovf"}, 64'(ovf), 64'(m_ovf));
    check({tagname, "_err"}, 64'(err), 64'(m_err));
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst && wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got addr %0h data %0h expected none (cycle %0d)",
                   wr_addr, wr_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr",  64'(wr_addr), 64'(e[EW-1 -: AW]));
          check("wr_data",  64'(wr_data), 64'(e[DW+31 -: DW]));
          check("wr_cycle", 64'(cyc),     64'(e[31:0]));
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [LANES*DW-1:0] pa;
    logic [LANES*DW-1:0] pb;
    int t0;
    int wait_n;

    rst         = 1'b0;
    add_done    = 1'b0;
    neuron_done = 1'b0;
    prod_data   = '0;
    out_addr    = '0;
    fork
      monitor();
    join_none

    idle(3);
    check("rst_wr_en",   64'(wr_en),   64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_ovf",     64'(ovf),     64'd0);
    check("rst_err",     64'(err),     64'd0);
    rst = 1'b1;
    idle(2);

    // single group of ones, tagged at T+1
    drive_group(fill(16'h0001), 1'b1, 1, 16'h0040);
    check("busy_in_write", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_after_write", 64'(busy), 64'd0);
    idle(11);
    check_flags("ones");

    // two groups accumulated into one neuron
    drive_group(fill(16'h0002), 1'b0, 1, 16'h0000);
    idle(12);
    drive_group(fill(16'h0003), 1'b1, 1, 16'h0005);
    idle(12);
    check_flags("two_groups");

    // DW saturation, sticky ovf
    for (int g = 0; g < 3; g++) begin
      drive_group(fill(16'h7FFF), g == 2, 1, 16'h0100);
      idle(12);
    end
    check_flags("sat");

    // negative result (-16, or 0 with ReLU)
    drive_group(fill(16'hFFFF), 1'b1, 1, 16'h0200);
    idle(12);
    check_flags("neg");

    // completion pulse with an empty tree, accumulator untouched
    drive_group(fill(16'h0001), 1'b0, 1, 16'h0000);
    idle(12);
    neuron_done = 1'b1;
    out_addr    = 16'h0BAD;
    m_err       = 1'b1;
    @(negedge clk);
    neuron_done = 1'b0;
    idle(3);
    check_flags("empty_tag");
    drive_group(fill(16'h0002), 1'b1, 1, 16'h0300);
    idle(12);

    // new group enters while a last group leaves the tree
    pa = rand_group();
    pb = rand_group();
    t0 = cyc;
    issue_model(pa, 1'b1, 16'h0400, t0);
    prod_data = pa; add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0; neuron_done = 1'b1; out_addr = 16'h0400;
    @(negedge clk);
    neuron_done = 1'b0;
    idle(3);
    issue_model(pb, 1'b1, 16'h0401, cyc);
    prod_data = pb; add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0; neuron_done = 1'b1; out_addr = 16'h0401;
    @(negedge clk);
    neuron_done = 1'b0;
    idle(16);
    check_flags("overlap");

    // random groups, random tag timing
    for (int g = 0; g < 24; g++) begin
      drive_group(rand_group(), $urandom_range(0, 2) == 0,
                  int'($urandom_range(1, 5)), AW'($urandom));
      idle(12);
    end
    check_flags("random");

    // close any open neuron, then reset in the middle of a tagged group
    drive_group(rand_group(), 1'b1, 1, 16'h0500);
    idle(12);
    prod_data = fill(16'h0005); add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0; neuron_done = 1'b1; out_addr = 16'h0600;
    @(negedge clk);
    neuron_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    m_acc = 0;
    m_ovf = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    check("busy_after_rst", 64'(busy), 64'd0);
    check_flags("after_rst");
    idle(10);
    drive_group(fill(16'h0001), 1'b1, 1, 16'h0700);
    idle(12);

    for (int g = 0; g < 6; g++) begin
      drive_group(rand_group(), $urandom_range(0, 1) == 0,
                  int'($urandom_range(1, 5)), AW'($urandom));
      idle(12);
    end
    drive_group(rand_group(), 1'b1, 5, 16'h0800);

    // drain with a bounded wait
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    check_flags("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
